// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Function codes are packed {s[0:3], m, ci}, with s[0] in the MSB.
package alu_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_MUL = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL_IT,
      ST_RESP
   } state_e;

   localparam logic [5:0] FC_ADD   = 6'b1001_0_1;
   localparam logic [5:0] FC_SUB   = 6'b0110_0_0;
   localparam logic [5:0] FC_AND   = 6'b1101_1_1;
   localparam logic [5:0] FC_OR    = 6'b0111_1_1;
   localparam logic [5:0] FC_XOR   = 6'b0110_1_1;
   localparam logic [5:0] FC_RESET = 6'b0000_0_1;

   function automatic logic [5:0] fc_of(input logic [2:0] op);
      logic [5:0] fc;
      fc = FC_ADD;
      case (op)
         OP_SUB:  fc = FC_SUB;
         OP_AND:  fc = FC_AND;
         OP_OR:   fc = FC_OR;
         OP_XOR:  fc = FC_XOR;
         default: fc = FC_ADD;
      endcase
      return fc;
   endfunction

   function automatic logic is_logic_op(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
   endfunction

endpackage

// File: rtl/alu_seq_mul_dp.sv
// Shift-add multiply datapath: accumulator, shifted multiplicand,
// consumed multiplier and iteration counter. The adder itself is the external ALU.
module alu_seq_mul_dp
   import alu_pkg::*;
#(
   parameter int MUL_ITERS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] alu_y,
   output logic [DATA_W-1:0] acc,
   output logic [DATA_W-1:0] mcand,
   output logic [DATA_W-1:0] acc_next,
   output logic              done
);

   localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

   logic [DATA_W-1:0] acc_reg;
   logic [DATA_W-1:0] mcand_reg;
   logic [DATA_W-1:0] mplier_reg;
   logic [CNT_W-1:0]  cnt_reg;

   // ALU is driven with acc + mcand; only keep the sum when the multiplier bit is set
   assign acc_next = mplier_reg[0] ? alu_y : acc_reg;
   assign done     = (cnt_reg == CNT_W'(MUL_ITERS - 1));
   assign acc      = acc_reg;
   assign mcand    = mcand_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
      end else if (load) begin
         acc_reg    <= '0;
         mcand_reg  <= a;
         mplier_reg <= b;
         cnt_reg    <= '0;
      end else if (step) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         cnt_reg    <= cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Command sequencer driving an external 74181-style 16-bit ALU.
// One command at a time in, one registered response out; MUL iterates on the ALU adder.
module alu_seq
   import alu_pkg::*;
#(
   parameter int MUL_ITERS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_y,
   output logic              rsp_carry,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [0:3]        alu_s,
   output logic              alu_m,
   output logic              alu_ci,
   output logic [0:DATA_W-1] alu_a,
   output logic [0:DATA_W-1] alu_b,
   input  logic [0:DATA_W-1] alu_y,
   input  logic              alu_co
);

   state_e            state_reg;
   logic [2:0]        op_reg;
   logic [DATA_W-1:0] opa_reg;
   logic [DATA_W-1:0] opb_reg;
   logic [5:0]        fc_reg;
   logic [DATA_W-1:0] y_reg;
   logic              carry_reg;
   logic              err_reg;

   logic [DATA_W-1:0] y_vec;
   logic [DATA_W-1:0] alu_a_vec;
   logic [DATA_W-1:0] alu_b_vec;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] acc_next;
   logic              mul_load;
   logic              mul_step;
   logic              mul_done;

   // ALU buses use ascending ranges; map bit i of a word to ALU index i explicitly
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bitmap
         assign alu_a[gi] = alu_a_vec[gi];
         assign alu_b[gi] = alu_b_vec[gi];
         assign y_vec[gi] = alu_y[gi];
      end
   endgenerate

   assign alu_a_vec = (state_reg == ST_MUL_IT) ? acc   : opa_reg;
   assign alu_b_vec = (state_reg == ST_MUL_IT) ? mcand : opb_reg;
   assign {alu_s, alu_m, alu_ci} = fc_reg;

   assign cmd_ready = (state_reg == ST_IDLE);
   assign rsp_valid = (state_reg == ST_RESP);
   assign rsp_y     = y_reg;
   assign rsp_carry = carry_reg;
   assign rsp_zero  = (y_reg == '0);
   assign rsp_err   = err_reg;

   assign mul_load = (state_reg == ST_IDLE) && cmd_valid && (cmd_op == OP_MUL);
   assign mul_step = (state_reg == ST_MUL_IT);

   alu_seq_mul_dp #(
      .MUL_ITERS (MUL_ITERS)
   ) u_mul_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (mul_load),
      .step     (mul_step),
      .a        (cmd_a),
      .b        (cmd_b),
      .alu_y    (y_vec),
      .acc      (acc),
      .mcand    (mcand),
      .acc_next (acc_next),
      .done     (mul_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         op_reg    <= '0;
         opa_reg   <= '0;
         opb_reg   <= '0;
         fc_reg    <= FC_RESET;
         y_reg     <= '0;
         carry_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_reg <= cmd_op;
                  case (cmd_op)
                     OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        opa_reg   <= cmd_a;
                        opb_reg   <= cmd_b;
                        fc_reg    <= fc_of(cmd_op);
                        state_reg <= ST_EXEC;
                     end
                     OP_MUL: begin
                        fc_reg    <= FC_ADD;
                        state_reg <= ST_MUL_IT;
                     end
                     default: begin
                        // illegal opcode: answer immediately, ALU untouched
                        y_reg     <= '0;
                        carry_reg <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               y_reg     <= y_vec;
               carry_reg <= is_logic_op(op_reg) ? 1'b0 : alu_co;
               err_reg   <= 1'b0;
               state_reg <= ST_RESP;
            end
            ST_MUL_IT: begin
               if (mul_done) begin
                  y_reg     <= acc_next;
                  carry_reg <= 1'b0;
                  err_reg   <= 1'b0;
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 74181-style ALU alongside.
// Each directed step compares against hand-computed values.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_y;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        rsp_err;
   logic [0:3]  alu_s;
   logic        alu_m;
   logic        alu_ci;
   logic [0:15] alu_a;
   logic [0:15] alu_b;
   logic [0:15] alu_y;
   logic        alu_co;

   int checks = 0;
   int errors = 0;
   int lat;
   logic [3:0]  s_seen;
   logic        m_seen;
   logic        ci_seen;
   logic [15:0] y_hold;

   alu_seq #(.MUL_ITERS(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .alu_s     (alu_s),
      .alu_m     (alu_m),
      .alu_ci    (alu_ci),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_y     (alu_y),
      .alu_co    (alu_co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: index i of each bus has weight 2^i; carry-out is active-low
   logic [15:0] ma, mb, my;
   logic [16:0] msum;
   logic        mco;

   always_comb begin
      ma = '0;
      mb = '0;
      for (int i = 0; i < 16; i++) begin
         ma[i] = alu_a[i];
         mb[i] = alu_b[i];
      end
   end

   always_comb begin
      my   = '0;
      msum = '0;
      mco  = 1'b1;
      case ({alu_s, alu_m, alu_ci})
         6'b100101: begin msum = {1'b0, ma} + {1'b0, mb};          my = msum[15:0]; mco = ~msum[16]; end
         6'b011000: begin msum = {1'b0, ma} + {1'b0, ~mb} + 17'd1; my = msum[15:0]; mco = ~msum[16]; end
         6'b110111: my = ma & mb;
         6'b011111: my = ma | mb;
         6'b011011: my = ma ^ mb;
         default:   my = '0;
      endcase
   end

   always_comb begin
      alu_y = '0;
      for (int i = 0; i < 16; i++) alu_y[i] = my[i];
   end
   assign alu_co = mco;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a command, wait for its accept edge, then count edges up to rsp_valid
   task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int latency);
      int guard;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("accept_timeout", 32'(guard < 50), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      s_seen  = alu_s;
      m_seen  = alu_m;
      ci_seen = alu_ci;
      latency = 1;
      while (!rsp_valid && latency < 40) begin
         @(posedge clk);
         #1;
         latency++;
      end
      $display("cmd op=%0d a=%h b=%h -> y=%h c=%0d z=%0d err=%0d lat=%0d",
               op, a, b, rsp_y, rsp_carry, rsp_zero, rsp_err, latency);
   endtask

   task automatic consume();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_y",     32'(rsp_y),     32'd0);
      check("rst_rsp_zero",  32'(rsp_zero),  32'd1);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      check("rst_alu_code",  32'({alu_s, alu_m, alu_ci}), 32'b000001);
      check("rst_alu_a",     32'(ma), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD
      run_cmd(3'd0, 16'h1234, 16'h0101, lat);
      check("add_code", 32'({s_seen, m_seen, ci_seen}), 32'b100101);
      check("add_lat",  32'(lat),      32'd2);
      check("add_y",    32'(rsp_y),    32'h1335);
      check("add_zero", 32'(rsp_zero), 32'd0);
      check("add_err",  32'(rsp_err),  32'd0);
      consume();

      // SUB
      run_cmd(3'd1, 16'h0005, 16'h0003, lat);
      check("sub_code", 32'({s_seen, m_seen, ci_seen}), 32'b011000);
      check("sub_y",    32'(rsp_y), 32'h0002);
      consume();

      // XOR to zero
      run_cmd(3'd4, 16'hAAAA, 16'hAAAA, lat);
      check("xor_y",     32'(rsp_y),     32'h0000);
      check("xor_zero",  32'(rsp_zero),  32'd1);
      check("xor_carry", 32'(rsp_carry), 32'd0);
      consume();

      // MUL 3*5
      run_cmd(3'd5, 16'h0003, 16'h0005, lat);
      check("mul_lat",   32'(lat),       32'd17);
      check("mul_y",     32'(rsp_y),     32'h000F);
      check("mul_carry", 32'(rsp_carry), 32'd0);
      consume();

      // MUL overflow to zero
      run_cmd(3'd5, 16'h0100, 16'h0100, lat);
      check("mul_ovf_y",    32'(rsp_y),    32'h0000);
      check("mul_ovf_zero", 32'(rsp_zero), 32'd1);
      consume();

      // MUL with multiple bits set: 0x1234 * 0x0056 = 0x61D78 -> 0x1D78
      run_cmd(3'd5, 16'h1234, 16'h0056, lat);
      check("mul_big_y", 32'(rsp_y), 32'h1D78);
      consume();

      // AND then backpressure with a waiting OR command
      run_cmd(3'd2, 16'hF0F0, 16'h3C3C, lat);
      check("and_code", 32'({s_seen, m_seen, ci_seen}), 32'b110111);
      check("and_y",    32'(rsp_y), 32'h3030);
      y_hold = rsp_y;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      cmd_a     = 16'hF0F0;
      cmd_b     = 16'h3C3C;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_y",     32'(rsp_y),     32'(y_hold));
         check("bp_ready", 32'(cmd_ready), 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("bp_post_hs_ready", 32'(cmd_ready), 32'd1);
      check("bp_post_hs_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("bp_accepted", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      check("or_valid", 32'(rsp_valid), 32'd1);
      check("or_y",     32'(rsp_y),     32'hFCFC);
      $display("cmd op=3 a=f0f0 b=3c3c -> y=%h (after backpressure)", rsp_y);
      consume();

      // Illegal opcode
      run_cmd(3'd7, 16'h1111, 16'h2222, lat);
      check("ill_lat", 32'(lat),     32'd1);
      check("ill_err", 32'(rsp_err), 32'd1);
      check("ill_y",   32'(rsp_y),   32'd0);
      consume();

      // Reset in the middle of a MUL
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      cmd_a     = 16'h0007;
      cmd_b     = 16'h0009;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mrst_rsp_y",     32'(rsp_y),     32'd0);
      check("mrst_rsp_zero",  32'(rsp_zero),  32'd1);
      check("mrst_alu_code",  32'({alu_s, alu_m, alu_ci}), 32'b000001);
      check("mrst_alu_b",     32'(mb), 32'd0);
      $display("reset asserted mid-MUL");
      @(negedge clk);
      rst_n = 1'b1;

      run_cmd(3'd0, 16'h00FF, 16'h0001, lat);
      check("post_rst_add_y",   32'(rsp_y), 32'h0100);
      check("post_rst_add_lat", 32'(lat),   32'd2);
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
